bpsk_tx_ctrl: RTL and testbench



---
 rtl/bpsk_pkg.sv | 17 +
 rtl/bpsk_symbol_timer.sv | 37 +++
 rtl/bpsk_tx_ctrl.sv | 170 +++++++++++++++++
 tb/tb_bpsk_tx_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/bpsk_pkg.sv
// Shared definitions for the BPSK transmit controller: state encoding and default timing.
package bpsk_pkg;

    localparam int BYTE_W             = 8;
    localparam int SPS_DEF            = 32;
    localparam int PREAMBLE_BITS_DEF  = 16;
    localparam int FLUSH_CYCLES_DEF   = 4;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_SINE = 3'd1,
        ST_PREAMBLE  = 3'd2,
        ST_PAYLOAD   = 3'd3,
        ST_FLUSH     = 3'd4
    } state_t;

endpackage

// File: rtl/bpsk_symbol_timer.sv
// Counts sine_rdy-qualified samples modulo SPS; strobes the symbol boundary and counts symbols.
module bpsk_symbol_timer #(
    parameter int SPS   = 32,
    parameter int BIT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             sine_rdy,
    output logic             boundary,
    output logic [BIT_W-1:0] bit_cnt
);

    localparam int SYM_W = (SPS > 1) ? $clog2(SPS) : 1;
    localparam logic [SYM_W-1:0] SYM_LAST = SYM_W'(SPS - 1);

    logic [SYM_W-1:0] sym_cnt;

    assign boundary = en & sine_rdy & (sym_cnt == SYM_LAST);

    // Samples without sine_rdy leave both counters untouched, so the symbol simply stretches.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            sym_cnt <= '0;
            bit_cnt <= '0;
        end else if (en && sine_rdy) begin
            if (sym_cnt == SYM_LAST) begin
                sym_cnt <= '0;
                bit_cnt <= bit_cnt + 1'b1;
            end else begin
                sym_cnt <= sym_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/bpsk_tx_ctrl.sv
// BPSK burst sequencer: preamble, then MSB-first payload from a one-byte holding register,
// then a short flush so the mixer pipeline drains before the sine enable drops.
module bpsk_tx_ctrl
    import bpsk_pkg::*;
#(
    parameter int SPS           = SPS_DEF,
    parameter int PREAMBLE_BITS = PREAMBLE_BITS_DEF,
    parameter int FLUSH_CYCLES  = FLUSH_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [BYTE_W-1:0] byte_data,
    input  logic              byte_last,
    output logic              byte_ready,
    input  logic              sine_rdy,
    output logic              clken,
    output logic              mod_ena,
    output logic              data,
    output logic              busy,
    output logic              done,
    output logic              underrun
);

    localparam int BIT_W = ($clog2(PREAMBLE_BITS + 1) > 3) ? $clog2(PREAMBLE_BITS + 1) : 3;
    localparam logic [BIT_W-1:0] PRE_LAST = BIT_W'((PREAMBLE_BITS > 0) ? PREAMBLE_BITS - 1 : 0);
    localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FW-1:0] FLUSH_LAST = FW'((FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0);

    state_t state, next_state;

    logic [BYTE_W-1:0] hold_data, shift_reg;
    logic              hold_full, hold_last, shift_last, last_taken;
    logic [FW-1:0]     flush_cnt;
    logic              mod_ena_q, done_q, underrun_q;

    logic              cnt_en, boundary, pre_done, byte_end, accept;
    logic [BIT_W-1:0]  bit_cnt;
    logic              enter_payload, load_hold, load_in, shift_en, set_underrun, flush_end;

    assign busy       = (state != ST_IDLE);
    assign clken      = busy;
    assign byte_ready = busy & ~hold_full & ~last_taken;
    assign accept     = byte_valid & byte_ready;
    assign cnt_en     = (state == ST_PREAMBLE) || (state == ST_PAYLOAD);
    assign pre_done   = (state == ST_PREAMBLE) && boundary && (bit_cnt == PRE_LAST);
    assign byte_end   = (state == ST_PAYLOAD) && boundary && (bit_cnt[2:0] == 3'd7);
    assign mod_ena    = mod_ena_q;
    assign done       = done_q;
    assign underrun   = underrun_q;

    always_comb begin
        data = 1'b0;
        if (state == ST_PREAMBLE)     data = ~bit_cnt[0];
        else if (state == ST_PAYLOAD) data = shift_reg[BYTE_W-1];
    end

    bpsk_symbol_timer #(
        .SPS   (SPS),
        .BIT_W (BIT_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clr      (~cnt_en | pre_done),
        .en       (cnt_en),
        .sine_rdy (sine_rdy),
        .boundary (boundary),
        .bit_cnt  (bit_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state    = state;
        enter_payload = 1'b0;
        load_hold     = 1'b0;
        load_in       = 1'b0;
        shift_en      = 1'b0;
        set_underrun  = 1'b0;
        flush_end     = 1'b0;
        case (state)
            ST_IDLE: if (start) next_state = ST_WAIT_SINE;
            ST_WAIT_SINE: begin
                if (sine_rdy) begin
                    if (PREAMBLE_BITS > 0) next_state = ST_PREAMBLE;
                    else                   enter_payload = 1'b1;
                end
            end
            ST_PREAMBLE: if (pre_done) enter_payload = 1'b1;
            ST_PAYLOAD: begin
                if (byte_end) begin
                    if (hold_full) begin
                        load_hold = 1'b1;
                    end else begin
                        next_state   = ST_FLUSH;
                        set_underrun = ~shift_last;
                    end
                end else if (boundary) begin
                    shift_en = 1'b1;
                end
            end
            ST_FLUSH: begin
                if (flush_cnt == FLUSH_LAST) begin
                    next_state = ST_IDLE;
                    flush_end  = 1'b1;
                end
            end
            default: next_state = ST_IDLE;
        endcase
        // A byte arriving on the very cycle payload starts is forwarded straight to the shifter.
        if (enter_payload) begin
            if (hold_full) begin
                next_state = ST_PAYLOAD;
                load_hold  = 1'b1;
            end else if (accept) begin
                next_state = ST_PAYLOAD;
                load_in    = 1'b1;
            end else begin
                next_state   = ST_FLUSH;
                set_underrun = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_data  <= '0;
            hold_last  <= 1'b0;
            hold_full  <= 1'b0;
            last_taken <= 1'b0;
            shift_reg  <= '0;
            shift_last <= 1'b0;
            flush_cnt  <= '0;
            mod_ena_q  <= 1'b0;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            mod_ena_q <= (next_state == ST_PREAMBLE) || (next_state == ST_PAYLOAD);
            done_q    <= flush_end;
            flush_cnt <= (state == ST_FLUSH) ? flush_cnt + 1'b1 : '0;
            if (state == ST_IDLE && start) begin
                underrun_q <= 1'b0;
                hold_full  <= 1'b0;
                last_taken <= 1'b0;
            end
            if (set_underrun) underrun_q <= 1'b1;
            if (accept) last_taken <= last_taken | byte_last;
            if (accept && !load_in) begin
                hold_data <= byte_data;
                hold_last <= byte_last;
                hold_full <= 1'b1;
            end
            if (load_hold) begin
                shift_reg  <= hold_data;
                shift_last <= hold_last;
                hold_full  <= 1'b0;
            end else if (load_in) begin
                shift_reg  <= byte_data;
                shift_last <= byte_last;
            end else if (shift_en) begin
                shift_reg <= {shift_reg[BYTE_W-2:0], 1'b0};
            end
        end
    end

endmodule

// File: tb/tb_bpsk_tx_ctrl.sv
// Bench for bpsk_tx_ctrl: two instances (with and without preamble) against a sample-count model.
module tb_bpsk_tx_ctrl;

    localparam int SPS   = 4;
    localparam int PRE   = 4;
    localparam int FLUSH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start_a, start_b, byte_valid, byte_last, sine_rdy;
    logic [7:0] byte_data;
    logic       ready_a, clken_a, mod_a, data_a, busy_a, done_a, unr_a;
    logic       ready_b, clken_b, mod_b, data_b, busy_b, done_b, unr_b;
    bit         sel_b;
    logic       o_ready, o_clken, o_mod, o_data, o_busy, o_done, o_unr;

    assign o_ready = sel_b ? ready_b : ready_a;
    assign o_clken = sel_b ? clken_b : clken_a;
    assign o_mod   = sel_b ? mod_b   : mod_a;
    assign o_data  = sel_b ? data_b  : data_a;
    assign o_busy  = sel_b ? busy_b  : busy_a;
    assign o_done  = sel_b ? done_b  : done_a;
    assign o_unr   = sel_b ? unr_b   : unr_a;

    bpsk_tx_ctrl #(.SPS(SPS), .PREAMBLE_BITS(PRE), .FLUSH_CYCLES(FLUSH)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_last(byte_last), .byte_ready(ready_a), .sine_rdy(sine_rdy), .clken(clken_a),
        .mod_ena(mod_a), .data(data_a), .busy(busy_a), .done(done_a), .underrun(unr_a)
    );

    bpsk_tx_ctrl #(.SPS(SPS), .PREAMBLE_BITS(0), .FLUSH_CYCLES(FLUSH)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_last(byte_last), .byte_ready(ready_b), .sine_rdy(sine_rdy), .clken(clken_b),
        .mod_ena(mod_b), .data(data_b), .busy(busy_b), .done(done_b), .underrun(unr_b)
    );

    int checks = 0;
    int failures = 0;

    bit         exp_bits[$];
    logic [7:0] tx_bytes[$];
    bit         tx_last;
    bit         exp_unr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string t, input bit em, input bit ed, input bit ecl,
                            input bit edn, input bit eu);
        chk({t, "/mod_ena"}, o_mod, em);
        chk({t, "/data"}, o_data, ed);
        chk({t, "/clken"}, o_clken, ecl);
        chk({t, "/busy"}, o_busy, ecl);
        chk({t, "/done"}, o_done, edn);
        chk({t, "/underrun"}, o_unr, eu);
    endtask

    // Expected symbol stream: alternating preamble from 1, then each byte MSB first.
    task automatic prep(input int pre_n);
        exp_bits.delete();
        for (int i = 0; i < pre_n; i++) exp_bits.push_back((i % 2) == 0);
        foreach (tx_bytes[j])
            for (int b = 7; b >= 0; b--) exp_bits.push_back(tx_bytes[j][b]);
        exp_unr = !tx_last;
    endtask

    task automatic drive_byte(input int idx);
        if (idx < tx_bytes.size()) begin
            byte_valid = 1'b1;
            byte_data  = tx_bytes[idx];
            byte_last  = tx_last && (idx == tx_bytes.size() - 1);
        end else begin
            byte_valid = 1'b0;
            byte_data  = 8'h00;
            byte_last  = 1'b0;
        end
    endtask

    // phase 0: waiting for first sine_rdy, 1: modulating, 2: flushing (k cycles in).
    // While modulating, the symbol on air is exp_bits[samples_seen / SPS].
    task automatic run_burst(input bit use_b, input int mode, input bit glitch, input int abort_at);
        int  idx, rcnt, k, c, phase, nbits, mcount;
        bit  fin, last_acc, acc, exp_d;
        idx = 0; rcnt = 0; k = 0; c = 0; phase = 0; mcount = 0;
        fin = 1'b0; last_acc = 1'b0;
        nbits = exp_bits.size();
        sel_b = use_b;
        @(negedge clk);
        drive_byte(idx);
        start_a  = !use_b;
        start_b  = use_b;
        sine_rdy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        while (c < 4000) begin
            exp_d = 1'b0;
            if (phase == 1) exp_d = exp_bits[rcnt / SPS];
            chk_outs($sformatf("c%0d", c), phase == 1, exp_d, !(phase == 2 && k == FLUSH),
                     phase == 2 && k == FLUSH, phase == 2 && exp_unr);
            if (last_acc) chk($sformatf("c%0d/byte_ready_after_last", c), o_ready, 0);
            if (phase == 1) mcount++;
            if (phase == 2 && k == FLUSH) begin
                fin = 1'b1;
                break;
            end
            if (abort_at >= 0 && phase == 1 && rcnt == abort_at) begin
                rst = 1'b1;
                byte_valid = 1'b0;
                @(posedge clk);
                @(negedge clk);
                rst = 1'b0;
                chk_outs("abort", 0, 0, 0, 0, 0);
                chk("abort/byte_ready", o_ready, 0);
                @(negedge clk);
                chk("abort/no_done", o_done, 0);
                chk("abort/idle", o_busy, 0);
                return;
            end
            start_a = 1'b0;
            start_b = 1'b0;
            if (glitch && ((phase == 1 && rcnt == 1) || (phase == 2 && k == 1))) begin
                start_a = !use_b;
                start_b = use_b;
            end
            case (mode)
                0:       sine_rdy = 1'b1;
                1:       sine_rdy = (c % 2) == 1;
                default: sine_rdy = ($urandom_range(0, 3) != 0);
            endcase
            drive_byte(idx);
            acc = byte_valid && o_ready;
            @(posedge clk);
            if (acc) begin
                if (byte_last) last_acc = 1'b1;
                idx++;
            end
            case (phase)
                0: if (sine_rdy) begin
                    if (nbits == 0) begin phase = 2; k = 0; end
                    else phase = 1;
                end
                1: if (sine_rdy) begin
                    rcnt++;
                    if (rcnt == nbits * SPS) begin phase = 2; k = 0; end
                end
                default: k++;
            endcase
            @(negedge clk);
            c++;
        end
        chk("burst_completed", fin, 1);
        if (mode == 0) chk("mod_ena_cycles", mcount, nbits * SPS);
        start_a = 1'b0;
        start_b = 1'b0;
        byte_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("post%0d/done", i), o_done, 0);
            chk($sformatf("post%0d/clken", i), o_clken, 0);
            chk($sformatf("post%0d/underrun", i), o_unr, exp_unr);
        end
    endtask

    initial begin
        int n;
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; byte_valid = 1'b0;
        byte_data = 8'h00; byte_last = 1'b0; sine_rdy = 1'b0; sel_b = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk_outs("reset_a", 0, 0, 0, 0, 0);
        chk("reset_a/byte_ready", o_ready, 0);
        sel_b = 1'b1;
        #1;
        chk_outs("reset_b", 0, 0, 0, 0, 0);
        chk("reset_b/byte_ready", o_ready, 0);

        // Two bytes, continuous sine samples, then with sine_rdy gated every other cycle.
        tx_bytes = '{8'hA5, 8'h3C}; tx_last = 1'b1; prep(PRE);
        run_burst(0, 0, 0, -1);
        run_burst(0, 1, 0, -1);

        // Single byte without last: underrun after it, sticky until the next start.
        tx_bytes = '{8'h55}; tx_last = 1'b0; prep(PRE);
        run_burst(0, 0, 0, -1);

        // Start pulses during preamble and flush must not disturb the burst.
        tx_bytes = '{8'h81}; tx_last = 1'b1; prep(PRE);
        run_burst(0, 0, 1, -1);

        // No preamble: byte waiting before start is sent from the first sine sample.
        tx_bytes = '{8'hFF}; tx_last = 1'b1; prep(0);
        run_burst(1, 0, 0, -1);

        // Nothing to send at payload entry, with and without a preamble.
        tx_bytes.delete(); tx_last = 1'b0; prep(0);
        run_burst(1, 0, 0, -1);
        prep(PRE);
        run_burst(0, 0, 0, -1);

        // Random payloads under random sine_rdy.
        for (int r = 0; r < 3; r++) begin
            tx_bytes.delete();
            n = $urandom_range(1, 3);
            for (int i = 0; i < n; i++) tx_bytes.push_back(8'($urandom_range(0, 255)));
            tx_last = 1'($urandom_range(0, 1));
            prep(PRE);
            run_burst(0, 2, 0, -1);
        end

        // Reset in the middle of the payload.
        tx_bytes = '{8'hC3, 8'h5A}; tx_last = 1'b1; prep(PRE);
        run_burst(0, 0, 0, (PRE + 3) * SPS + 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
